// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: latches a byte and steps the registered TX mux select through start/data/parity/stop.
// Latency: DATA_VALID in IDLE at edge N gives MUX_SEL=00 after edge N; DATA_VALID is only honoured in IDLE/STOP, so hold it until BUSY rises.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            MUX_SEL,
  output logic                  SER_DATA,
  output logic                  PAR_BIT,
  output logic                  BUSY
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  localparam logic [1:0] SEL_START  = 2'b00;
  localparam logic [1:0] SEL_STOP   = 2'b01;
  localparam logic [1:0] SEL_DATA   = 2'b10;
  localparam logic [1:0] SEL_PARITY = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Everything a frame needs, captured together so mid-frame input changes cannot leak in.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  par_en;
    logic                  par_typ;
  } frame_cfg_t;

  state_t           state;
  state_t           state_nxt;
  frame_cfg_t       cfg_q;
  logic [CNT_W-1:0] bit_cnt;
  logic             load;

  assign load = DATA_VALID && ((state == IDLE) || (state == STOP));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cfg_q   <= '0;
      bit_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        cfg_q   <= '{data: P_DATA, par_en: PAR_EN, par_typ: PAR_TYP};
        bit_cnt <= '0;
      end else if ((state == DATA) && (bit_cnt != LAST_BIT)) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (DATA_VALID) state_nxt = START;
      START:   state_nxt = DATA;
      DATA: begin
        if (bit_cnt == LAST_BIT) state_nxt = cfg_q.par_en ? PARITY : STOP;
      end
      PARITY:  state_nxt = STOP;
      STOP:    state_nxt = DATA_VALID ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    MUX_SEL = SEL_STOP;
    BUSY    = 1'b1;
    case (state)
      IDLE:    BUSY    = 1'b0;
      START:   MUX_SEL = SEL_START;
      DATA:    MUX_SEL = SEL_DATA;
      PARITY:  MUX_SEL = SEL_PARITY;
      STOP:    MUX_SEL = SEL_STOP;
      default: BUSY    = 1'b0;
    endcase
  end

  // Both bits come straight from the latches, so they are defined in every state.
  assign SER_DATA = cfg_q.data[bit_cnt];
  assign PAR_BIT  = (^cfg_q.data) ^ cfg_q.par_typ;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: one task per scenario, inline checks, one summary line.
module tb_uart_tx_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [1:0] MUX_SEL;
  logic       SER_DATA;
  logic       PAR_BIT;
  logic       BUSY;

  int total = 0;
  int bad   = 0;

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .MUX_SEL    (MUX_SEL),
    .SER_DATA   (SER_DATA),
    .PAR_BIT    (PAR_BIT),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b1; DATA_VALID = 1'b1; P_DATA = 8'hFF; PAR_EN = 1'b1; PAR_TYP = 1'b1;
    tick; tick;
    total++;
    if (MUX_SEL !== 2'b01 || BUSY !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl: mux=%b busy=%b want mux=01 busy=0", MUX_SEL, BUSY);
    end
    total++;
    if (SER_DATA !== 1'b0 || PAR_BIT !== 1'b0) begin
      bad++; $display("FAIL reset_bits: ser=%b par=%b want 0 0", SER_DATA, PAR_BIT);
    end
    RST = 1'b0; DATA_VALID = 1'b0;
    tick;
    total++;
    if (MUX_SEL !== 2'b01 || BUSY !== 1'b0) begin
      bad++; $display("FAIL reset_no_frame: mux=%b busy=%b want mux=01 busy=0", MUX_SEL, BUSY);
    end
  endtask

  task automatic test_no_parity;
    logic [7:0] d;
    int busy_n;
    d = 8'hA5; busy_n = 0;
    P_DATA = d; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    tick;
    DATA_VALID = 1'b0;
    busy_n += int'(BUSY);
    total++;
    if (MUX_SEL !== 2'b00 || BUSY !== 1'b1) begin
      bad++; $display("FAIL nopar_start: mux=%b busy=%b want mux=00 busy=1", MUX_SEL, BUSY);
    end
    for (int i = 0; i < 8; i++) begin
      tick;
      busy_n += int'(BUSY);
      total++;
      if (MUX_SEL !== 2'b10 || SER_DATA !== d[i]) begin
        bad++; $display("FAIL nopar_data%0d: mux=%b ser=%b want mux=10 ser=%b", i, MUX_SEL, SER_DATA, d[i]);
      end
    end
    tick;
    busy_n += int'(BUSY);
    total++;
    if (MUX_SEL !== 2'b01 || BUSY !== 1'b1 || PAR_BIT !== 1'b0) begin
      bad++; $display("FAIL nopar_stop: mux=%b busy=%b par=%b want mux=01 busy=1 par=0", MUX_SEL, BUSY, PAR_BIT);
    end
    tick;
    busy_n += int'(BUSY);
    total++;
    if (MUX_SEL !== 2'b01 || BUSY !== 1'b0) begin
      bad++; $display("FAIL nopar_idle: mux=%b busy=%b want mux=01 busy=0", MUX_SEL, BUSY);
    end
    total++;
    if (busy_n != 10) begin
      bad++; $display("FAIL nopar_busy_len: got %0d want 10", busy_n);
    end
  endtask

  task automatic test_parity(input logic typ, input logic exp_par);
    logic [7:0] d;
    int busy_n;
    d = 8'hA5; busy_n = 0;
    P_DATA = d; PAR_EN = 1'b1; PAR_TYP = typ; DATA_VALID = 1'b1;
    tick;
    DATA_VALID = 1'b0;
    busy_n += int'(BUSY);
    total++;
    if (MUX_SEL !== 2'b00 || PAR_BIT !== exp_par) begin
      bad++; $display("FAIL par%0d_start: mux=%b par=%b want mux=00 par=%b", typ, MUX_SEL, PAR_BIT, exp_par);
    end
    for (int i = 0; i < 8; i++) begin
      tick;
      busy_n += int'(BUSY);
      if (MUX_SEL !== 2'b10 || SER_DATA !== d[i]) begin
        total++; bad++;
        $display("FAIL par%0d_data%0d: mux=%b ser=%b want mux=10 ser=%b", typ, i, MUX_SEL, SER_DATA, d[i]);
      end
    end
    tick;
    busy_n += int'(BUSY);
    total++;
    if (MUX_SEL !== 2'b11 || PAR_BIT !== exp_par) begin
      bad++; $display("FAIL par%0d_bit: mux=%b par=%b want mux=11 par=%b", typ, MUX_SEL, PAR_BIT, exp_par);
    end
    tick;
    busy_n += int'(BUSY);
    tick;
    busy_n += int'(BUSY);
    total++;
    if (MUX_SEL !== 2'b01 || BUSY !== 1'b0 || busy_n != 11) begin
      bad++; $display("FAIL par%0d_len: mux=%b busy=%b busy_cycles=%0d want mux=01 busy=0 busy_cycles=11", typ, MUX_SEL, BUSY, busy_n);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] d1;
    logic [7:0] d2;
    d1 = 8'h01; d2 = 8'hFF;
    P_DATA = d1; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    tick;
    P_DATA = d2;
    total++;
    if (MUX_SEL !== 2'b00 || BUSY !== 1'b1) begin
      bad++; $display("FAIL b2b_start1: mux=%b busy=%b want mux=00 busy=1", MUX_SEL, BUSY);
    end
    for (int i = 0; i < 8; i++) begin
      tick;
      if (MUX_SEL !== 2'b10 || SER_DATA !== d1[i]) begin
        total++; bad++;
        $display("FAIL b2b_data1_%0d: mux=%b ser=%b want mux=10 ser=%b", i, MUX_SEL, SER_DATA, d1[i]);
      end
    end
    tick;
    total++;
    if (MUX_SEL !== 2'b01 || BUSY !== 1'b1) begin
      bad++; $display("FAIL b2b_stop1: mux=%b busy=%b want mux=01 busy=1", MUX_SEL, BUSY);
    end
    tick;
    DATA_VALID = 1'b0;
    total++;
    if (MUX_SEL !== 2'b00 || BUSY !== 1'b1) begin
      bad++; $display("FAIL b2b_start2: mux=%b busy=%b want mux=00 busy=1 (no idle gap)", MUX_SEL, BUSY);
    end
    for (int i = 0; i < 8; i++) begin
      tick;
      total++;
      if (MUX_SEL !== 2'b10 || SER_DATA !== d2[i]) begin
        bad++; $display("FAIL b2b_data2_%0d: mux=%b ser=%b want mux=10 ser=%b", i, MUX_SEL, SER_DATA, d2[i]);
      end
    end
    tick;
    tick;
    total++;
    if (MUX_SEL !== 2'b01 || BUSY !== 1'b0) begin
      bad++; $display("FAIL b2b_idle: mux=%b busy=%b want mux=01 busy=0", MUX_SEL, BUSY);
    end
  endtask

  task automatic test_midframe_change;
    logic [7:0] d;
    d = 8'hA5;
    P_DATA = d; PAR_EN = 1'b1; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    tick;
    DATA_VALID = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (i == 1) begin
        P_DATA = 8'h00; PAR_TYP = 1'b1; PAR_EN = 1'b0;
      end
      total++;
      if (MUX_SEL !== 2'b10 || SER_DATA !== d[i]) begin
        bad++; $display("FAIL chg_data%0d: mux=%b ser=%b want mux=10 ser=%b", i, MUX_SEL, SER_DATA, d[i]);
      end
    end
    tick;
    total++;
    if (MUX_SEL !== 2'b11 || PAR_BIT !== 1'b0) begin
      bad++; $display("FAIL chg_parity: mux=%b par=%b want mux=11 par=0", MUX_SEL, PAR_BIT);
    end
    tick;
    tick;
    total++;
    if (MUX_SEL !== 2'b01 || BUSY !== 1'b0) begin
      bad++; $display("FAIL chg_idle: mux=%b busy=%b want mux=01 busy=0", MUX_SEL, BUSY);
    end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] d;
    int busy_n;
    P_DATA = 8'hA5; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    tick;
    DATA_VALID = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    total++;
    if (MUX_SEL !== 2'b10 || SER_DATA !== 1'b0) begin
      bad++; $display("FAIL rstmid_bit3: mux=%b ser=%b want mux=10 ser=0", MUX_SEL, SER_DATA);
    end
    RST = 1'b1;
    tick;
    RST = 1'b0;
    total++;
    if (MUX_SEL !== 2'b01 || BUSY !== 1'b0) begin
      bad++; $display("FAIL rstmid_abort: mux=%b busy=%b want mux=01 busy=0", MUX_SEL, BUSY);
    end
    tick;
    total++;
    if (MUX_SEL !== 2'b01 || BUSY !== 1'b0) begin
      bad++; $display("FAIL rstmid_stay_idle: mux=%b busy=%b want mux=01 busy=0", MUX_SEL, BUSY);
    end
    // 0x3C has four ones; odd parity gives 1.
    d = 8'h3C; busy_n = 0;
    P_DATA = d; PAR_EN = 1'b1; PAR_TYP = 1'b1; DATA_VALID = 1'b1;
    tick;
    DATA_VALID = 1'b0;
    busy_n += int'(BUSY);
    total++;
    if (MUX_SEL !== 2'b00) begin
      bad++; $display("FAIL rstmid_restart: mux=%b want 00", MUX_SEL);
    end
    for (int i = 0; i < 8; i++) begin
      tick;
      busy_n += int'(BUSY);
      total++;
      if (MUX_SEL !== 2'b10 || SER_DATA !== d[i]) begin
        bad++; $display("FAIL rstmid_data%0d: mux=%b ser=%b want mux=10 ser=%b", i, MUX_SEL, SER_DATA, d[i]);
      end
    end
    tick;
    busy_n += int'(BUSY);
    total++;
    if (MUX_SEL !== 2'b11 || PAR_BIT !== 1'b1) begin
      bad++; $display("FAIL rstmid_parity: mux=%b par=%b want mux=11 par=1", MUX_SEL, PAR_BIT);
    end
    tick;
    busy_n += int'(BUSY);
    tick;
    busy_n += int'(BUSY);
    total++;
    if (BUSY !== 1'b0 || busy_n != 11) begin
      bad++; $display("FAIL rstmid_len: busy=%b busy_cycles=%0d want busy=0 busy_cycles=11", BUSY, busy_n);
    end
  endtask

  initial begin
    RST = 1'b1; DATA_VALID = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    test_reset;
    test_no_parity;
    test_parity(1'b0, 1'b0);
    test_parity(1'b1, 1'b1);
    test_back_to_back;
    test_midframe_change;
    test_reset_midframe;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
